tlb_op_ctrl: RTL and testbench

- Multi-cycle sequencer for the privileged TLB instructions TLBP, TLBR, TLBWI and TLBWR.
- Sits between the MEM-stage pipeline and the shared TLB/CP0 pair:
  - accepts one TLB op at a time;
  - drives the TLB search, read and write ports;
  - produces the CP0 write-enables and data for EntryHi/EntryLo0/EntryLo1/Index;
  - stalls the pipeline while busy and requests a refetch after any TLB write.

---
 rtl/tlb_pkg.sv | 46 ++++
 rtl/tlb_op_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_tlb_op_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_pkg.sv
// -----------------------------------------------------------------------------
// tlb_pkg
// Shared definitions for the TLB instruction sequencer:
//   - TLB op_code values (TLBP / TLBR / TLBWI / TLBWR)
//   - sequencer state encoding
//   - EntryHi / EntryLo field bit positions
//   - helper that forms the EntryHi value written into the TLB
// -----------------------------------------------------------------------------
package tlb_pkg;

    localparam logic [1:0] TLBOP_P  = 2'd0;
    localparam logic [1:0] TLBOP_R  = 2'd1;
    localparam logic [1:0] TLBOP_WI = 2'd2;
    localparam logic [1:0] TLBOP_WR = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PROBE    = 3'd1,
        ST_PROBE_WB = 3'd2,
        ST_READ     = 3'd3,
        ST_READ_WB  = 3'd4,
        ST_WRITE    = 3'd5
    } tlb_state_e;

    // EntryHi fields
    localparam int HI_VPN2_MSB = 31;
    localparam int HI_VPN2_LSB = 13;
    localparam int HI_ASID_MSB = 7;
    localparam int HI_ASID_LSB = 0;

    // EntryLo fields
    localparam int LO_PFN_MSB = 25;
    localparam int LO_PFN_LSB = 6;
    localparam int LO_C_MSB   = 5;
    localparam int LO_C_LSB   = 3;
    localparam int LO_D       = 2;
    localparam int LO_V       = 1;
    localparam int LO_G       = 0;

    // EntryHi as stored in the TLB: bits between VPN2 and ASID are reserved
    // and always written as zero.
    function automatic logic [31:0] hi_for_write(input logic [31:0] hi);
        return {hi[HI_VPN2_MSB:HI_VPN2_LSB], 5'b00000, hi[HI_ASID_MSB:HI_ASID_LSB]};
    endfunction

endpackage

// File: rtl/tlb_op_ctrl.sv
// -----------------------------------------------------------------------------
// tlb_op_ctrl
// Multi-cycle sequencer for TLBP, TLBR, TLBWI and TLBWR between the MEM stage
// and the shared TLB / CP0 pair.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   op_valid/op_code/op_ready  op handshake from MEM stage
//   cancel                   abort from an older-stage exception/flush
//   cp0_*                    CP0 EntryHi/EntryLo0/EntryLo1/Index/Random
//   s_req/s_vpn2/s_asid, s_found/s_index    TLB search port
//   r_req/r_index, r_hi/r_lo0/r_lo1         TLB read port
//   tlb_we/w_index/w_hi/w_lo0/w_lo1         TLB write port
//   *_Wren/*_in, s1_found    CP0 update strobes and data
//   busy, done, refetch      pipeline stall, completion, refetch request
// -----------------------------------------------------------------------------
module tlb_op_ctrl
    import tlb_pkg::*;
#(
    parameter int TLBNUM = 16,
    parameter int IDX_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [1:0]       op_code,
    output logic             op_ready,
    input  logic             cancel,
    input  logic [31:0]      cp0_entryhi,
    input  logic [31:0]      cp0_entrylo0,
    input  logic [31:0]      cp0_entrylo1,
    input  logic [31:0]      cp0_index,
    input  logic [31:0]      cp0_random,
    output logic             s_req,
    output logic [18:0]      s_vpn2,
    output logic [7:0]       s_asid,
    input  logic             s_found,
    input  logic [IDX_W-1:0] s_index,
    output logic             r_req,
    output logic [IDX_W-1:0] r_index,
    input  logic [31:0]      r_hi,
    input  logic [31:0]      r_lo0,
    input  logic [31:0]      r_lo1,
    output logic             tlb_we,
    output logic [IDX_W-1:0] w_index,
    output logic [31:0]      w_hi,
    output logic [31:0]      w_lo0,
    output logic [31:0]      w_lo1,
    output logic             Index_Wren,
    output logic [31:0]      Index_in,
    output logic             s1_found,
    output logic             EntryHi_Wren,
    output logic [31:0]      EntryHi_in,
    output logic             EntryLo0_Wren,
    output logic [31:0]      EntryLo0_in,
    output logic             EntryLo1_Wren,
    output logic [31:0]      EntryLo1_in,
    output logic             busy,
    output logic             done,
    output logic             refetch
);

    tlb_state_e       state_r;
    logic [IDX_W-1:0] idx_r;          // latched Index operand (probe-miss writeback)
    logic             index_wren_r;
    logic             entry_wren_r;   // EntryHi/Lo0/Lo1 are always updated together
    logic             g_s;
    logic             unused_s;

    // A page is global only if both halves of the pair are marked global.
    assign g_s = cp0_entrylo0[LO_G] & cp0_entrylo1[LO_G];

    // Upper Index/Random bits never address an entry.
    assign unused_s = ^{cp0_index[31:IDX_W], cp0_random[31:IDX_W], TLBNUM[0]};

    assign op_ready = (state_r == ST_IDLE);
    assign busy     = (state_r != ST_IDLE);

    // Search/read results arrive the cycle after the strobe, so the CP0
    // writeback data is muxed straight from the TLB, gated by the registered
    // Wren so the data lines stay at zero whenever the strobe is low.
    assign Index_Wren    = index_wren_r;
    assign s1_found      = index_wren_r & s_found;
    assign Index_in      = !index_wren_r ? 32'd0 :
                           (s_found ? {{(32-IDX_W){1'b0}}, s_index}
                                    : {{(32-IDX_W){1'b0}}, idx_r});
    assign EntryHi_Wren  = entry_wren_r;
    assign EntryLo0_Wren = entry_wren_r;
    assign EntryLo1_Wren = entry_wren_r;
    assign EntryHi_in    = entry_wren_r ? r_hi  : 32'd0;
    assign EntryLo0_in   = entry_wren_r ? r_lo0 : 32'd0;
    assign EntryLo1_in   = entry_wren_r ? r_lo1 : 32'd0;

    // Sequencer FSM. Port strobes and data for the PROBE/READ/WRITE states are
    // registered on the acceptance edge from the CP0 values present then, so
    // those output registers double as the operand latch: later CP0 changes
    // cannot reach the op.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            idx_r        <= {IDX_W{1'b0}};
            index_wren_r <= 1'b0;
            entry_wren_r <= 1'b0;
            s_req        <= 1'b0;
            s_vpn2       <= 19'd0;
            s_asid       <= 8'd0;
            r_req        <= 1'b0;
            r_index      <= {IDX_W{1'b0}};
            tlb_we       <= 1'b0;
            w_index      <= {IDX_W{1'b0}};
            w_hi         <= 32'd0;
            w_lo0        <= 32'd0;
            w_lo1        <= 32'd0;
            done         <= 1'b0;
            refetch      <= 1'b0;
        end else begin
            // every strobe is a single-cycle pulse
            index_wren_r <= 1'b0;
            entry_wren_r <= 1'b0;
            s_req        <= 1'b0;
            s_vpn2       <= 19'd0;
            s_asid       <= 8'd0;
            r_req        <= 1'b0;
            r_index      <= {IDX_W{1'b0}};
            tlb_we       <= 1'b0;
            w_index      <= {IDX_W{1'b0}};
            w_hi         <= 32'd0;
            w_lo0        <= 32'd0;
            w_lo1        <= 32'd0;
            done         <= 1'b0;
            refetch      <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (op_valid && !cancel) begin
                        idx_r <= cp0_index[IDX_W-1:0];
                        case (op_code)
                            TLBOP_P: begin
                                state_r <= ST_PROBE;
                                s_req   <= 1'b1;
                                s_vpn2  <= cp0_entryhi[HI_VPN2_MSB:HI_VPN2_LSB];
                                s_asid  <= cp0_entryhi[HI_ASID_MSB:HI_ASID_LSB];
                            end
                            TLBOP_R: begin
                                state_r <= ST_READ;
                                r_req   <= 1'b1;
                                r_index <= cp0_index[IDX_W-1:0];
                            end
                            default: begin
                                // TLBWI / TLBWR: the write itself is the commit
                                state_r <= ST_WRITE;
                                tlb_we  <= 1'b1;
                                done    <= 1'b1;
                                refetch <= 1'b1;
                                w_index <= (op_code == TLBOP_WR) ? cp0_random[IDX_W-1:0]
                                                                 : cp0_index[IDX_W-1:0];
                                w_hi    <= hi_for_write(cp0_entryhi);
                                w_lo0   <= {cp0_entrylo0[31:1], g_s};
                                w_lo1   <= {cp0_entrylo1[31:1], g_s};
                            end
                        endcase
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_PROBE: begin
                    if (cancel) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r      <= ST_PROBE_WB;
                        index_wren_r <= 1'b1;
                        done         <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (cancel) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r      <= ST_READ_WB;
                        entry_wren_r <= 1'b1;
                        done         <= 1'b1;
                    end
                end
                // writeback/write cycles have committed; cancel is ignored
                ST_PROBE_WB: state_r <= ST_IDLE;
                ST_READ_WB:  state_r <= ST_IDLE;
                ST_WRITE:    state_r <= ST_IDLE;
                default:     state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tlb_op_ctrl
// Self-checking bench for tlb_op_ctrl. Each cycle of an op is compared, as a
// whole output vector, against values derived from the op's architectural
// effect (what should be searched/read/written and what CP0 should receive).
// -----------------------------------------------------------------------------
module tb_tlb_op_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic [1:0]  op_code = 2'd0;
    logic        op_ready;
    logic        cancel = 1'b0;
    logic [31:0] cp0_entryhi = 32'd0, cp0_entrylo0 = 32'd0, cp0_entrylo1 = 32'd0;
    logic [31:0] cp0_index = 32'd0, cp0_random = 32'd0;
    logic        s_req;
    logic [18:0] s_vpn2;
    logic [7:0]  s_asid;
    logic        s_found = 1'b0;
    logic [3:0]  s_index = 4'd0;
    logic        r_req;
    logic [3:0]  r_index;
    logic [31:0] r_hi = 32'd0, r_lo0 = 32'd0, r_lo1 = 32'd0;
    logic        tlb_we;
    logic [3:0]  w_index;
    logic [31:0] w_hi, w_lo0, w_lo1;
    logic        Index_Wren;
    logic [31:0] Index_in;
    logic        s1_found;
    logic        EntryHi_Wren, EntryLo0_Wren, EntryLo1_Wren;
    logic [31:0] EntryHi_in, EntryLo0_in, EntryLo1_in;
    logic        busy, done, refetch;

    int n_checks = 0;
    int n_fail   = 0;

    tlb_op_ctrl #(.TLBNUM(16), .IDX_W(4)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready), .cancel(cancel),
        .cp0_entryhi(cp0_entryhi), .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
        .cp0_index(cp0_index), .cp0_random(cp0_random),
        .s_req(s_req), .s_vpn2(s_vpn2), .s_asid(s_asid), .s_found(s_found), .s_index(s_index),
        .r_req(r_req), .r_index(r_index), .r_hi(r_hi), .r_lo0(r_lo0), .r_lo1(r_lo1),
        .tlb_we(tlb_we), .w_index(w_index), .w_hi(w_hi), .w_lo0(w_lo0), .w_lo1(w_lo1),
        .Index_Wren(Index_Wren), .Index_in(Index_in), .s1_found(s1_found),
        .EntryHi_Wren(EntryHi_Wren), .EntryHi_in(EntryHi_in),
        .EntryLo0_Wren(EntryLo0_Wren), .EntryLo0_in(EntryLo0_in),
        .EntryLo1_Wren(EntryLo1_Wren), .EntryLo1_in(EntryLo1_in),
        .busy(busy), .done(done), .refetch(refetch)
    );

    always #5 clk = ~clk;

    // expected values, one per DUT output
    logic        e_op_ready, e_busy, e_done, e_refetch, e_s_req, e_r_req, e_tlb_we;
    logic [18:0] e_s_vpn2;
    logic [7:0]  e_s_asid;
    logic [3:0]  e_r_index, e_w_index;
    logic [31:0] e_w_hi, e_w_lo0, e_w_lo1;
    logic        e_index_wren, e_s1_found, e_hi_wren, e_lo0_wren, e_lo1_wren;
    logic [31:0] e_index_in, e_hi_in, e_lo0_in, e_lo1_in;

    logic [270:0] obs, ev;
    assign obs = {op_ready, busy, done, refetch, s_req, s_vpn2, s_asid, r_req, r_index,
                  tlb_we, w_index, w_hi, w_lo0, w_lo1, Index_Wren, Index_in, s1_found,
                  EntryHi_Wren, EntryHi_in, EntryLo0_Wren, EntryLo0_in, EntryLo1_Wren, EntryLo1_in};
    assign ev  = {e_op_ready, e_busy, e_done, e_refetch, e_s_req, e_s_vpn2, e_s_asid, e_r_req, e_r_index,
                  e_tlb_we, e_w_index, e_w_hi, e_w_lo0, e_w_lo1, e_index_wren, e_index_in, e_s1_found,
                  e_hi_wren, e_hi_in, e_lo0_wren, e_lo0_in, e_lo1_wren, e_lo1_in};

    // Idle controller: ready, nothing asserted, all data lines zero.
    task automatic expect_idle();
        {e_busy, e_done, e_refetch, e_s_req, e_r_req, e_tlb_we} = 6'd0;
        e_s_vpn2 = 19'd0; e_s_asid = 8'd0; e_r_index = 4'd0; e_w_index = 4'd0;
        e_w_hi = 32'd0; e_w_lo0 = 32'd0; e_w_lo1 = 32'd0;
        {e_index_wren, e_s1_found, e_hi_wren, e_lo0_wren, e_lo1_wren} = 5'd0;
        e_index_in = 32'd0; e_hi_in = 32'd0; e_lo0_in = 32'd0; e_lo1_in = 32'd0;
        e_op_ready = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        cp0_entryhi = $urandom; cp0_entrylo0 = $urandom; cp0_entrylo1 = $urandom;
        cp0_index = $urandom; cp0_random = $urandom;
        s_found = 1'($urandom); s_index = 4'($urandom);
        r_hi = $urandom; r_lo0 = $urandom; r_lo1 = $urandom;
    endtask

    // Issue one op from idle and check every cycle until the controller is
    // idle again. cancel_cyc: 0 none, 1 = during T+1, 2 = during T+2.
    task automatic run_op(input logic [1:0] op, input logic [31:0] hi, input logic [31:0] lo0,
                          input logic [31:0] lo1, input logic [31:0] idx, input logic [31:0] rnd,
                          input int cancel_cyc, input logic found, input logic [3:0] sidx,
                          input logic [31:0] rhi, input logic [31:0] rlo0, input logic [31:0] rlo1,
                          input string tag);
        logic g;
        logic two_cycle;
        two_cycle = (op == 2'd0 || op == 2'd1) && cancel_cyc != 1;
        // cycle T: present the op
        op_valid = 1'b1; op_code = op; cancel = 1'b0;
        cp0_entryhi = hi; cp0_entrylo0 = lo0; cp0_entrylo1 = lo1;
        cp0_index = idx; cp0_random = rnd;
        step();
        // T+1: CP0 moves on; pipeline keeps a (junk) op_valid while stalled
        scramble_inputs();
        op_code  = 2'($urandom);
        op_valid = (op == 2'd0 || op == 2'd1) && cancel_cyc != 1;
        cancel   = (cancel_cyc == 1);
        expect_idle();
        e_op_ready = 1'b0; e_busy = 1'b1;
        if (op == 2'd0) begin
            e_s_req = 1'b1; e_s_vpn2 = hi[31:13]; e_s_asid = hi[7:0];
        end else if (op == 2'd1) begin
            e_r_req = 1'b1; e_r_index = idx[3:0];
        end else begin
            g = lo0[0] & lo1[0];
            e_tlb_we = 1'b1; e_done = 1'b1; e_refetch = 1'b1;
            e_w_index = (op == 2'd3) ? rnd[3:0] : idx[3:0];
            e_w_hi  = {hi[31:13], 5'd0, hi[7:0]};
            e_w_lo0 = {lo0[31:1], g};
            e_w_lo1 = {lo1[31:1], g};
        end
        #1;
        n_checks++;
        if (obs !== ev) begin
            n_fail++;
            $display("FAIL %s T+1: got %h want %h", tag, obs, ev);
        end
        // T+2: TLB returns search/read results
        step();
        scramble_inputs();
        s_found = found; s_index = sidx; r_hi = rhi; r_lo0 = rlo0; r_lo1 = rlo1;
        op_valid = 1'b0;
        cancel = (cancel_cyc == 2);
        expect_idle();
        if (two_cycle) begin
            e_op_ready = 1'b0; e_busy = 1'b1; e_done = 1'b1;
            if (op == 2'd0) begin
                e_index_wren = 1'b1; e_s1_found = found;
                e_index_in = found ? {28'd0, sidx} : {28'd0, idx[3:0]};
            end else begin
                e_hi_wren = 1'b1; e_lo0_wren = 1'b1; e_lo1_wren = 1'b1;
                e_hi_in = rhi; e_lo0_in = rlo0; e_lo1_in = rlo1;
            end
        end
        #1;
        n_checks++;
        if (obs !== ev) begin
            n_fail++;
            $display("FAIL %s T+2: got %h want %h", tag, obs, ev);
        end
        if (two_cycle) begin
            step();
            scramble_inputs();
            cancel = 1'b0;
            expect_idle();
            #1;
            n_checks++;
            if (obs !== ev) begin
                n_fail++;
                $display("FAIL %s T+3: got %h want %h", tag, obs, ev);
            end
        end
        cancel = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        scramble_inputs();
        op_valid = 1'b1;
        step(); step(); step();
        expect_idle();
        #1;
        n_checks++;
        if (obs !== ev) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", obs, ev);
        end
        op_valid = 1'b0;
        rst = 1'b1;
        step();
        #1;
        n_checks++;
        if (obs !== ev) begin
            n_fail++;
            $display("FAIL reset_release: got %h want %h", obs, ev);
        end
    endtask

    task automatic test_probe();
        run_op(2'd0, 32'h0040_2005, $urandom, $urandom, 32'h0000_000B, $urandom,
               0, 1'b1, 4'd7, $urandom, $urandom, $urandom, "tlbp_hit");
        run_op(2'd0, $urandom, $urandom, $urandom, 32'h0000_0003, $urandom,
               0, 1'b0, 4'd12, $urandom, $urandom, $urandom, "tlbp_miss");
    endtask

    task automatic test_read();
        run_op(2'd1, $urandom, $urandom, $urandom, 32'h0000_0012, $urandom,
               0, 1'b1, 4'd5, 32'hABCD_E0FF, 32'h0123_4567, 32'h89AB_CDEF, "tlbr");
        run_op(2'd1, $urandom, $urandom, $urandom, 32'h0000_001F, $urandom,
               0, 1'b0, 4'd0, $urandom, $urandom, $urandom, "tlbr_wrap");
    endtask

    task automatic test_write();
        run_op(2'd3, 32'hFFFF_FFFF, 32'h0000_1F47, 32'h0000_2F46, 32'h0000_0002, 32'h0000_0009,
               0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0, "tlbwr_latch");
        run_op(2'd2, 32'h1234_5F78, 32'h0000_0003, 32'h0000_0005, 32'h0000_001F, 32'h0000_0004,
               0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0, "tlbwi_global");
    endtask

    task automatic test_cancel();
        // cancel while idle blocks acceptance
        op_valid = 1'b1; op_code = 2'd2; cancel = 1'b1;
        step();
        op_valid = 1'b0; cancel = 1'b0;
        expect_idle();
        #1;
        n_checks++;
        if (obs !== ev) begin
            n_fail++;
            $display("FAIL cancel_idle: got %h want %h", obs, ev);
        end
        run_op(2'd1, $urandom, $urandom, $urandom, 32'h0000_0006, $urandom,
               1, 1'b1, 4'd1, $urandom, $urandom, $urandom, "cancel_read");
        run_op(2'd0, $urandom, $urandom, $urandom, 32'h0000_0006, $urandom,
               1, 1'b1, 4'd1, $urandom, $urandom, $urandom, "cancel_probe");
        run_op(2'd2, $urandom, $urandom, $urandom, 32'h0000_0008, $urandom,
               1, 1'b0, 4'd0, $urandom, $urandom, $urandom, "cancel_write");
        run_op(2'd0, $urandom, $urandom, $urandom, 32'h0000_0008, $urandom,
               2, 1'b1, 4'd9, $urandom, $urandom, $urandom, "cancel_probe_wb");
    endtask

    task automatic test_reset_midop();
        op_valid = 1'b1; op_code = 2'd0; cp0_entryhi = $urandom;
        step();
        op_valid = 1'b0;
        rst = 1'b0;
        step();
        s_found = 1'b1; s_index = 4'($urandom);
        expect_idle();
        #1;
        n_checks++;
        if (obs !== ev) begin
            n_fail++;
            $display("FAIL reset_midop: got %h want %h", obs, ev);
        end
        rst = 1'b1;
        step();
        #1;
        n_checks++;
        if (obs !== ev) begin
            n_fail++;
            $display("FAIL reset_midop_after: got %h want %h", obs, ev);
        end
        run_op(2'd2, $urandom, $urandom, $urandom, $urandom, $urandom,
               0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0, "tlbwi_after_reset");
    endtask

    task automatic test_random();
        int cc;
        for (int i = 0; i < 40; i++) begin
            cc = int'($urandom_range(0, 5));
            if (cc > 2) cc = 0;
            run_op(2'($urandom), $urandom, $urandom, $urandom, $urandom, $urandom,
                   cc, 1'($urandom), 4'($urandom), $urandom, $urandom, $urandom, "random_op");
        end
    endtask

    initial begin
        test_reset();
        test_probe();
        test_read();
        test_write();
        test_cancel();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
